serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits; legal range 2 to 64.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 SHALL have port sub, input, 1 bit: operation select; 0 = A+B, 1 = A-B.
REQ-006 SHALL have port op_a, input, WIDTH bits: operand A.
REQ-007 SHALL have port op_b, input, WIDTH bits: operand B.
REQ-008 SHALL have port busy, output, 1 bit: operation in progress.
REQ-009 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-010 SHALL have port result, output, WIDTH bits: sum or difference.
REQ-011 SHALL have port cout, output, 1 bit: carry out of the MSB; for subtraction, 1 means no borrow.
REQ-012 SHALL have port overflow, output, 1 bit: two's-complement signed overflow.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-014 SHALL accept start only when busy=0, that is in IDLE or DONE; a start sampled in RUN SHALL be ignored and leave no side effect.
REQ-015 On an accepted start edge, SHALL perform all of the following:
- latch op_a into the A shift register;
- latch op_b into the B shift register, inverted bitwise when sub=1;
- set the carry flip-flop to sub;
- clear the bit counter;
- enter RUN.
REQ-016 In RUN, on each edge, SHALL:
- compute the full-adder sum and carry of A[0], B[0] and the carry flip-flop;
- shift the sum into result from the MSB side;
- shift A and B right by one;
- update the carry flip-flop;
- increment the counter.
REQ-017 SHALL leave RUN after exactly WIDTH RUN edges and enter DONE.
- done is high for the cycle following the edge that is WIDTH edges after the start edge.
- Example: start sampled at edge 0, done high after edge 32 for WIDTH=32.
REQ-018 SHALL leave DONE for IDLE after one cycle, unless start is accepted in DONE; in that case the next state is RUN.
REQ-019 SHALL drive busy=1 only in RUN, and done=1 only in DONE.
REQ-020 SHALL drive cout from the final carry flip-flop.
REQ-021 SHALL drive overflow as carry-into-MSB XOR carry-out-of-MSB, captured on the last RUN edge.
REQ-022 SHALL hold result, cout and overflow stable from DONE until the next accepted start; their values during RUN are don't-care.
REQ-023 SHALL sample op_a, op_b and sub only on the accepted start edge; later changes to these inputs SHALL NOT affect the operation in flight.
REQ-024 SHALL perform arithmetic modulo 2^WIDTH: the carry out of the MSB is reported only on cout and never widens result.

Reset
REQ-025 While rst_n=0, SHALL asynchronously force all of the following, regardless of clk:
- state to IDLE;
- busy=0, done=0;
- result=0, cout=0, overflow=0;
- counter, shift registers and carry flip-flop to 0.
REQ-026 If reset asserts in RUN, SHALL abort the operation with no done pulse; after rst_n rises, SHALL wait for a new start.
REQ-027 SHALL NOT accept a start on the first edge at which rst_n is already high, and SHALL require no additional synchronization cycles after that edge.

Verification
REQ-028 Add wrap: op_a=0xFFFFFFFF, op_b=0x00000001, sub=0 -> done after edge 32; result=0x00000000, cout=1, overflow=0.
REQ-029 Signed overflow:
- 0x7FFFFFFF + 0x00000001 -> result=0x80000000, cout=0, overflow=1;
- 0x80000000 - 0x00000001 -> result=0x7FFFFFFF, cout=1, overflow=1.
REQ-030 Subtract: 5-3 -> result=0x00000002, cout=1, overflow=0; 3-5 -> result=0xFFFFFFFE, cout=0, overflow=0.
REQ-031 Start during busy: at edge 10 of 0x0000000A+0x00000005, pulse start with op_a=0x12345678 and change op_b -> result=0x0000000F, done still after edge 32, exactly one done pulse.
REQ-032 Reset mid-run: assert rst_n=0 at edge 15 -> busy=0, result=0 immediately, no done pulse; after reset, 1+1 -> result=0x00000002.
REQ-033 Back-to-back: start held high through DONE -> second operation begins with no IDLE cycle; two done pulses 33 cycles apart.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder evaluation per clock, LSB first.
// Result is shifted in from the MSB side so it is aligned after WIDTH steps.
module serial_adder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             armed;

   logic sum_bit;
   logic carry_next;
   logic last;
   logic accept;

   always_comb begin
      sum_bit    = sh_a[0] ^ sh_b[0] ^ carry;
      carry_next = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
      last       = (cnt == CW'(WIDTH - 1));
      // armed stays low for the first edge after reset release, so that edge never accepts start
      accept     = start & armed & (state != RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         sh_a     <= '0;
         sh_b     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         armed    <= 1'b0;
      end else begin
         armed <= 1'b1;
         if (accept) begin
            sh_a  <= op_a;
            sh_b  <= sub ? ~op_b : op_b;
            carry <= sub;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
         end else begin
            case (state)
               RUN: begin
                  result <= {sum_bit, result[WIDTH-1:1]};
                  sh_a   <= {1'b0, sh_a[WIDTH-1:1]};
                  sh_b   <= {1'b0, sh_b[WIDTH-1:1]};
                  carry  <= carry_next;
                  cnt    <= cnt + 1'b1;
                  if (last) begin
                     // carry still holds the carry into the MSB on this edge
                     cout     <= carry_next;
                     overflow <= carry ^ carry_next;
                     state    <= DONE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end
               end
               DONE: begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
